bist_sequencer: RTL

//  Run controller for the bus-invert encode/decode test datapath. On start it ramps the five stage

---
 rtl/bist_seq_pkg.sv | 28 ++
 rtl/bist_sequencer_if.sv | 47 ++++
 rtl/bist_en_shifter.sv | 42 ++++
 rtl/bist_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bist_seq_pkg.sv
// ---------------------------------------------------------------------------
// bist_seq_pkg
//  Shared definitions for the BIST run controller of the bus-invert
//  encode/decode test datapath: the controller state encoding, the number of
//  pipeline stages and the bit position of each stage in the enable chain.
// ---------------------------------------------------------------------------
package bist_seq_pkg;

   // Run controller states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Number of datapath stages driven by the enable chain.
   localparam int N_STAGES = 5;

   // Bit index of each stage inside the enable chain.
   localparam int STG_GEN = 0;   // vector generator
   localparam int STG_ENC = 1;   // bus-invert encoder
   localparam int STG_BUS = 2;   // bus model
   localparam int STG_DEC = 3;   // decoder
   localparam int STG_CMP = 4;   // comparator and transition counter

endpackage

// File: rtl/bist_sequencer_if.sv
// ---------------------------------------------------------------------------
// bist_sequencer_if
//  Control/status bundle between the BIST run controller and its environment.
//  Parameters:
//   VEC_W  width of first_err_idx
//   ERR_W  width of err_cnt
//  Signals:
//   start, abort, isequal         environment -> controller
//   en_gen_data .. en_trans_count stage enables, controller -> datapath
//   en_gen_err                    reserved, constant 0
//   done, busy                    run status
//   err_cnt, first_err_idx        run result
//  Modports:
//   slave   the controller (bist_sequencer)
//   master  the environment that starts runs and supplies comparator results
// ---------------------------------------------------------------------------
interface bist_sequencer_if #(
   parameter int VEC_W = 11,
   parameter int ERR_W = 16
);
   logic             start;
   logic             abort;
   logic             isequal;
   logic             en_gen_data;
   logic             en_enc;
   logic             en_bus;
   logic             en_dec;
   logic             en_k_comp;
   logic             en_trans_count;
   logic             en_gen_err;
   logic             done;
   logic             busy;
   logic [ERR_W-1:0] err_cnt;
   logic [VEC_W-1:0] first_err_idx;

   modport slave (
      input  start, abort, isequal,
      output en_gen_data, en_enc, en_bus, en_dec, en_k_comp, en_trans_count,
             en_gen_err, done, busy, err_cnt, first_err_idx
   );

   modport master (
      output start, abort, isequal,
      input  en_gen_data, en_enc, en_bus, en_dec, en_k_comp, en_trans_count,
             en_gen_err, done, busy, err_cnt, first_err_idx
   );
endinterface

// File: rtl/bist_en_shifter.sv
// ---------------------------------------------------------------------------
// bist_en_shifter
//  Stage-enable shift chain. Every clock the chain shifts one place towards
//  the last stage and fill_bit enters at stage 0, so a run of ones ramps the
//  stages up one cycle apart and a run of zeros drains them in the same order.
//  Ports:
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous active-high reset, clears the chain
//   fill_bit  in   1  value shifted into stage 0
//   en_vec    out  N  registered stage enables, bit 0 = first stage
//   all_on    out  1  every stage currently enabled
//   all_off   out  1  no stage currently enabled
// ---------------------------------------------------------------------------
module bist_en_shifter
   import bist_seq_pkg::*;
#(
   parameter int N = N_STAGES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fill_bit,
   output logic [N-1:0] en_vec,
   output logic         all_on,
   output logic         all_off
);

   logic [N-1:0] en_vec_r;

   // Shift chain register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_vec_r <= {N{1'b0}};
      end else begin
         en_vec_r <= {en_vec_r[N-2:0], fill_bit};
      end
   end

   assign en_vec  = en_vec_r;
   assign all_on  = &en_vec_r;
   assign all_off = ~|en_vec_r;

endmodule

// File: rtl/bist_sequencer.sv
// ---------------------------------------------------------------------------
// bist_sequencer
//  Run controller for the bus-invert encode/decode test datapath. A run ramps
//  the five stage enables one cycle apart, issues N_VECTORS vectors, drains
//  the pipeline in the same order, pulses done and reports the number of
//  comparator mismatches and the index of the first one.
//  Parameters:
//   N_VECTORS  vectors per run, must be >= N_STAGES
//   VEC_W      width of vector/check counters, 2**VEC_W > N_VECTORS
//   ERR_W      mismatch counter width, saturates at all-ones
//  Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset (shared with the datapath)
//   bus   bist_sequencer_if.slave: start/abort/isequal in; stage enables,
//         done, busy, err_cnt, first_err_idx out (all registered)
//  Configuration:
//   BIST_STOP_ON_ERR_EN  when defined, the first mismatch seen while vectors
//                        are still being issued stops issuing (like abort);
//                        checks already in flight are still counted.
// ---------------------------------------------------------------------------
module bist_sequencer
   import bist_seq_pkg::*;
#(
   parameter int N_VECTORS = 2000,
   parameter int VEC_W     = 11,
   parameter int ERR_W     = 16
) (
   input  logic            clk,
   input  logic            rst,
   bist_sequencer_if.slave bus
);

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(N_VECTORS - 1);
   localparam logic [VEC_W-1:0] IDX_NONE = {VEC_W{1'b1}};
   localparam logic [VEC_W-1:0] VEC_ONE  = {{(VEC_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

   if (N_VECTORS < N_STAGES) begin : g_bad_nvec
      $error("bist_sequencer: N_VECTORS must be >= N_STAGES");
   end
   if ((2 ** VEC_W) <= N_VECTORS) begin : g_bad_vecw
      $error("bist_sequencer: VEC_W too small for N_VECTORS");
   end

   state_t                state_r;
   state_t                state_s;
   logic                  fill_s;
   logic                  accept_s;
   logic                  last_vec_s;
   logic                  mismatch_s;
   logic                  stop_s;
   logic [N_STAGES-1:0]   en_vec_s;
   logic                  all_on_s;
   logic                  all_off_s;
   logic                  chk_valid_r;
   logic                  done_r;
   logic                  busy_r;
   logic [VEC_W-1:0]      vec_cnt_r;
   logic [VEC_W-1:0]      chk_idx_r;
   logic [VEC_W-1:0]      first_err_idx_r;
   logic [ERR_W-1:0]      err_cnt_r;

   bist_en_shifter #(.N(N_STAGES)) u_en_shifter (
      .clk      (clk),
      .rst      (rst),
      .fill_bit (fill_s),
      .en_vec   (en_vec_s),
      .all_on   (all_on_s),
      .all_off  (all_off_s)
   );

   // vec_cnt counts vectors already issued, so LAST_VEC means this shift issues the final one.
   assign last_vec_s = (vec_cnt_r == LAST_VEC);
   assign mismatch_s = chk_valid_r & ~bus.isequal;

`ifdef BIST_STOP_ON_ERR_EN
   assign stop_s = bus.abort | mismatch_s;
`else
   assign stop_s = bus.abort;
`endif

   // Next-state and fill decode; a stop request clears fill in the same cycle so no further vector enters.
   always_comb begin
      state_s  = state_r;
      fill_s   = 1'b0;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s  = FILL;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         FILL: begin
            if (stop_s) begin
               state_s = DRAIN;
            end else begin
               fill_s = 1'b1;
               if (last_vec_s) begin
                  state_s = DRAIN;
               end else if (all_on_s) begin
                  state_s = RUN;
               end else begin
                  state_s = FILL;
               end
            end
         end
         RUN: begin
            if (stop_s) begin
               state_s = DRAIN;
            end else begin
               fill_s = 1'b1;
               if (last_vec_s) begin
                  state_s = DRAIN;
               end else begin
                  state_s = RUN;
               end
            end
         end
         DRAIN: begin
            if (all_off_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register, registered status flags and the one-cycle check delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
         chk_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         done_r      <= (state_s == DONE);
         busy_r      <= (state_s != IDLE);
         chk_valid_r <= en_vec_s[STG_CMP];
      end
   end

   // Vector/check counters and the mismatch result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_cnt_r       <= {VEC_W{1'b0}};
         chk_idx_r       <= {VEC_W{1'b0}};
         err_cnt_r       <= {ERR_W{1'b0}};
         first_err_idx_r <= IDX_NONE;
      end else if (accept_s) begin
         vec_cnt_r       <= {VEC_W{1'b0}};
         chk_idx_r       <= {VEC_W{1'b0}};
         err_cnt_r       <= {ERR_W{1'b0}};
         first_err_idx_r <= IDX_NONE;
      end else begin
         if (fill_s) begin
            vec_cnt_r <= vec_cnt_r + VEC_ONE;
         end
         if (chk_valid_r) begin
            chk_idx_r <= chk_idx_r + VEC_ONE;
         end
         if (mismatch_s) begin
            if (err_cnt_r != ERR_MAX) begin
               err_cnt_r <= err_cnt_r + ERR_ONE;
            end
            if (first_err_idx_r == IDX_NONE) begin
               first_err_idx_r <= chk_idx_r;
            end
         end
      end
   end

   assign bus.en_gen_data    = en_vec_s[STG_GEN];
   assign bus.en_enc         = en_vec_s[STG_ENC];
   assign bus.en_bus         = en_vec_s[STG_BUS];
   assign bus.en_dec         = en_vec_s[STG_DEC];
   assign bus.en_k_comp      = en_vec_s[STG_CMP];
   assign bus.en_trans_count = en_vec_s[STG_CMP];
   assign bus.en_gen_err     = 1'b0;
   assign bus.done           = done_r;
   assign bus.busy           = busy_r;
   assign bus.err_cnt        = err_cnt_r;
   assign bus.first_err_idx  = first_err_idx_r;

endmodule
